godson_apb_timer: RTL

APB responder peripheral for the godson MCU: a prescaled up-counter with period wrap, compare-driven PWM output and an overflow interrupt, programmed over the CPU's APB0 port. It sits on the far side of the CPU's `apb0_*` initiator signals, drives the CPU's `apb0_ack` and `apb0_prdata`, and feeds one bit of the CPU `interrupt` vector and an LED/PWM pin.

---
 rtl/godson_apb_pkg.sv | 15 +
 rtl/godson_apb_resp_if.sv | 46 ++++
 rtl/godson_apb_timer.sv | 80 ++++++++
 3 files changed

// File: rtl/godson_apb_pkg.sv
// godson_apb_pkg: shared APB register map, CTRL field layout and bus FSM states
package godson_apb_pkg;
  localparam int NUM_REGS = 5;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_COMPARE = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam int CTRL_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;
  typedef enum logic {ST_IDLE, ST_ACK} apb_state_t;
endpackage

// File: rtl/godson_apb_resp_if.sv
// godson_apb_resp_if: APB responder FSM, word decode, write strobes and registered read data
module godson_apb_resp_if
  import godson_apb_pkg::*;
#(
  parameter int ADDR_APB = 32,
  parameter int DATA_APB_32 = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  apb_psel,
  input  logic [ADDR_APB-1:0]                   apb_paddr,
  input  logic                                  apb_pwrite,
  input  logic                                  apb_penable,
  input  logic [NUM_REGS-1:0][DATA_APB_32-1:0]  rd_regs,
  output logic [DATA_APB_32-1:0]                apb_prdata,
  output logic                                  apb_ack,
  output logic [NUM_REGS-1:0]                   wr_sel
);
  apb_state_t state;
  logic start;
  logic [2:0] idx;
  logic [7:0][DATA_APB_32-1:0] rd_tab;
  logic unused_addr;
  assign idx = apb_paddr[4:2];
  assign start = (state == ST_IDLE) & apb_psel & apb_penable;
  assign rd_tab = {{(8-NUM_REGS)*DATA_APB_32{1'b0}}, rd_regs};
  assign wr_sel = {NUM_REGS{start & apb_pwrite}} & NUM_REGS'(1 << idx);
  assign unused_addr = ^{apb_paddr[ADDR_APB-1:5], apb_paddr[1:0]};
  // accept in IDLE, ack for exactly one cycle, then drop read data
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      apb_ack <= 1'b0;
      apb_prdata <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state <= ST_ACK;
        apb_ack <= 1'b1;
        apb_prdata <= rd_tab[idx];
      end
    end else begin
      state <= ST_IDLE;
      apb_ack <= 1'b0;
      apb_prdata <= '0;
    end
endmodule

// File: rtl/godson_apb_timer.sv
// godson_apb_timer: prescaled period timer with compare PWM and overflow interrupt on APB
module godson_apb_timer
  import godson_apb_pkg::*;
#(
  parameter int ADDR_APB = 32,
  parameter int DATA_APB_32 = 32,
  parameter int CNT_W = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   apb_psel,
  input  logic [ADDR_APB-1:0]    apb_paddr,
  input  logic                   apb_pwrite,
  input  logic                   apb_penable,
  input  logic [DATA_APB_32-1:0] apb_pwdata,
  output logic [DATA_APB_32-1:0] apb_prdata,
  output logic                   apb_ack,
  output logic                   irq,
  output logic                   pwm_out
);
  logic en, irq_en, oneshot, ovf, tick, wrap, ovf_set, w1c, unused_wdata;
  logic [7:0] prescale, pre_cnt;
  logic [CNT_W-1:0] period, compare, count;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0][DATA_APB_32-1:0] rd_regs;
  godson_apb_resp_if #(.ADDR_APB(ADDR_APB), .DATA_APB_32(DATA_APB_32)) u_resp (
    .clock(clock), .reset(reset), .apb_psel(apb_psel), .apb_paddr(apb_paddr),
    .apb_pwrite(apb_pwrite), .apb_penable(apb_penable), .rd_regs(rd_regs),
    .apb_prdata(apb_prdata), .apb_ack(apb_ack), .wr_sel(wr_sel)
  );
  assign rd_regs[REG_CTRL] = DATA_APB_32'({prescale, 5'b0, oneshot, irq_en, en});
  assign rd_regs[REG_PERIOD] = DATA_APB_32'(period);
  assign rd_regs[REG_COMPARE] = DATA_APB_32'(compare);
  assign rd_regs[REG_COUNT] = DATA_APB_32'(count);
  assign rd_regs[REG_STATUS] = DATA_APB_32'(ovf);
  assign tick = en & (pre_cnt == prescale);
  assign wrap = tick & (count == period);
  assign ovf_set = wrap & ~wr_sel[REG_COUNT];
  assign w1c = wr_sel[REG_STATUS] & apb_pwdata[0];
  assign unused_wdata = ^apb_pwdata;
  // configuration registers; a CTRL write beats the one-shot auto-disable
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      en <= 1'b0;
      irq_en <= 1'b0;
      oneshot <= 1'b0;
      prescale <= '0;
      period <= '0;
      compare <= '0;
    end else begin
      if (wr_sel[REG_CTRL]) begin
        en <= apb_pwdata[CTRL_EN];
        irq_en <= apb_pwdata[CTRL_IRQ_EN];
        oneshot <= apb_pwdata[CTRL_ONESHOT];
        prescale <= apb_pwdata[CTRL_PRE_MSB:CTRL_PRE_LSB];
      end else if (ovf_set & oneshot) en <= 1'b0;
      if (wr_sel[REG_PERIOD]) period <= apb_pwdata[CNT_W-1:0];
      if (wr_sel[REG_COMPARE]) compare <= apb_pwdata[CNT_W-1:0];
    end
  // prescaler, period counter and overflow flag; COUNT write overrides a tick, hardware set beats W1C
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pre_cnt <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      pre_cnt <= (wr_sel[REG_COUNT] | ~en | tick) ? 8'd0 : pre_cnt + 8'd1;
      count <= (wr_sel[REG_COUNT] | wrap) ? '0 : tick ? count + CNT_W'(1) : count;
      ovf <= ovf_set | (ovf & ~w1c);
    end
  // registered PWM and interrupt outputs
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pwm_out <= 1'b0;
      irq <= 1'b0;
    end else begin
      pwm_out <= en & (count < compare);
      irq <= ovf & irq_en;
    end
endmodule
